// File: rtl/seq_decoder_if.sv
// Load/select bus between a sequencer controller and seq_decoder.
// IN_W must match the IN_W of the seq_decoder instance it connects to.
interface seq_decoder_if #(
    parameter int IN_W = 2
);
    localparam int OUT_W = 2**IN_W;

    logic             en;
    logic             clear;
    logic             mode;
    logic             scan_wrap;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  decoder_in;
    logic [OUT_W-1:0] decoder_out;
    logic             out_valid;
    logic             busy;
    logic             done;

    modport master (
        output en, clear, mode, scan_wrap, in_valid, decoder_in,
        input  in_ready, decoder_out, out_valid, busy, done
    );

    modport slave (
        input  en, clear, mode, scan_wrap, in_valid, decoder_in,
        output in_ready, decoder_out, out_valid, busy, done
    );
endinterface

// File: rtl/seq_decoder.sv
// Registered one-hot decoder with a scan sequencer that steps the select
// across consecutive addresses, holding each for DWELL enabled cycles.
module seq_decoder #(
    parameter int IN_W  = 2,
    parameter int DWELL = 1
) (
    input  logic        clk,
    input  logic        rst,
    seq_decoder_if.slave bus
);
    localparam int OUT_W = 2**IN_W;
    localparam int CNT_W = $clog2(DWELL + 1);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [IN_W-1:0]  ADDR_TOP   = IN_W'(OUT_W - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_SCAN = 2'd2;

    logic [1:0]       state;
    logic [IN_W-1:0]  addr;
    logic [IN_W-1:0]  visit_cnt;
    logic [CNT_W-1:0] dwell_cnt;
    logic             wrap_q;
    logic [OUT_W-1:0] dec_q;
    logic             vld_q;
    logic             busy_q;
    logic             done_q;

    logic             in_ready;
    logic             accept;
    logic             last;
    logic [IN_W-1:0]  addr_nxt;

    function automatic logic [OUT_W-1:0] onehot(input logic [IN_W-1:0] a);
        logic [OUT_W-1:0] r;
        r    = '0;
        r[a] = 1'b1;
        return r;
    endfunction

    assign in_ready = bus.en & ~bus.clear & (state != ST_SCAN);
    assign accept   = bus.in_valid & in_ready;

    // Wrap scans count visits so every address is shown exactly once;
    // non-wrap scans simply stop at the top address.
    assign last     = wrap_q ? (visit_cnt == ADDR_TOP) : (addr == ADDR_TOP);
    assign addr_nxt = addr + IN_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr      <= '0;
            visit_cnt <= '0;
            dwell_cnt <= '0;
            wrap_q    <= 1'b0;
            dec_q     <= '0;
            vld_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (bus.clear) begin
            state     <= ST_IDLE;
            dec_q     <= '0;
            vld_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (bus.en) begin
            done_q <= 1'b0;
            if (accept) begin
                dec_q <= onehot(bus.decoder_in);
                vld_q <= 1'b1;
                if (bus.mode) begin
                    addr      <= bus.decoder_in;
                    dwell_cnt <= '0;
                    visit_cnt <= '0;
                    wrap_q    <= bus.scan_wrap;
                    busy_q    <= 1'b1;
                    state     <= ST_SCAN;
                end else begin
                    state <= ST_HOLD;
                end
            end else if (state == ST_SCAN) begin
                if (dwell_cnt != DWELL_LAST) begin
                    dwell_cnt <= dwell_cnt + CNT_W'(1);
                end else begin
                    dwell_cnt <= '0;
                    if (last) begin
                        dec_q  <= '0;
                        vld_q  <= 1'b0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= ST_IDLE;
                    end else begin
                        addr      <= addr_nxt;
                        dec_q     <= onehot(addr_nxt);
                        visit_cnt <= visit_cnt + IN_W'(1);
                    end
                end
            end
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.decoder_out = dec_q;
    assign bus.out_valid   = vld_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: doc/seq_decoder.md
Name: seq_decoder

Overview:
- Parametrised IN_W-to-2^IN_W one-hot decoder with a registered output and a valid/ready load interface.
- Adds a scan mode that steps the one-hot select across consecutive addresses, holding each for DWELL cycles. Scan either stops at the top address or wraps and visits every address once.
- Used as the row/bank select sequencer in front of array blocks. It replaces the fixed 2-to-4 combinational decoder.

Parameters:
- IN_W, 2, address width; output width OUT_W = 2**IN_W (localparam, not overridable); legal range 1..6.
- DWELL, 1, cycles each address is held in scan mode; legal range 1..255; counter width = clog2(DWELL+1).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  clock enable; 0 freezes all state.
- clear  input  1  synchronous abort/clear.
- mode  input  1  0 = direct decode, 1 = scan; sampled only on load acceptance.
- scan_wrap  input  1  scan end policy; sampled only on load acceptance.
- in_valid  input  1  load request.
- in_ready  output  1  load can be accepted this cycle.
- decoder_in  input  IN_W  decode address / scan start address.
- decoder_out  output  OUT_W  registered one-hot select (or all-zero).
- out_valid  output  1  decoder_out holds a valid select.
- busy  output  1  scan in progress.
- done  output  1  one-cycle pulse at scan completion.

Behaviour:
- Reset (async, immediate): decoder_out=0, out_valid=0, busy=0, done=0. Internal state: addr=0, dwell_cnt=0, visit_cnt=0, state=IDLE.
- States: IDLE (no valid output), HOLD (direct result held), SCAN.
- in_ready = en & ~clear & (state != SCAN). It is combinational and does not depend on in_valid.
- Accept = in_valid & in_ready at a clock edge.
- done defaults to 0 every enabled cycle. It is 1 only in the cycle after the terminating scan edge.
- Priority: rst > clear > en=0 > accept > scan stepping.
- clear=1 (en ignored) sets decoder_out=0, out_valid=0, busy=0, done=0 and state=IDLE. It aborts a scan without a done pulse.
- en=0 with clear=0: all registers hold, including done. in_ready=0.
- Direct accept (mode=0) from IDLE or HOLD:
  - decoder_out <= 1<<decoder_in, out_valid<=1, state=HOLD.
  - Latency is 1 clock. The value holds until the next accept or clear.
  - Back-to-back accepts update every cycle.
- Scan accept (mode=1) from IDLE or HOLD:
  - addr<=decoder_in, decoder_out<=1<<decoder_in, out_valid<=1, busy<=1.
  - dwell_cnt<=0, visit_cnt<=0, latch scan_wrap, state=SCAN.
- SCAN, each enabled cycle:
  - If dwell_cnt != DWELL-1: dwell_cnt++.
  - Otherwise dwell_cnt<=0 and the step decision is made:
    - last = scan_wrap ? (visit_cnt == OUT_W-1) : (addr == OUT_W-1).
    - If last: decoder_out<=0, out_valid<=0, busy<=0, done<=1, state=IDLE.
    - Else: addr<=addr+1 (mod OUT_W, wraps OUT_W-1 -> 0), decoder_out<=1<<(addr+1), visit_cnt++.
- Each address is visible for exactly DWELL cycles.
  - Non-wrap scan from start s shows addresses s..OUT_W-1.
  - Wrap scan shows exactly OUT_W addresses starting at s.
- A scan started at OUT_W-1 with wrap=0 shows one address, then done.
- decoder_out is always all-zero or exactly one-hot. out_valid=1 iff it is one-hot.
- in_valid during SCAN is ignored (in_ready=0). No queuing.
- mode and scan_wrap changes outside accept have no effect.

Test Plan (IN_W=2, DWELL=2 unless stated):
- Reset: assert rst mid-scan asynchronously -> decoder_out=0000, out_valid=0, busy=0, done=0 immediately, with no clock edge needed.
- Direct: accept 2, then 0, then 3 on consecutive cycles -> decoder_out=0100, 0001, 1000 one cycle after each accept; in_ready stays 1; holds 1000 afterwards.
- Scan non-wrap, start=1:
  - decoder_out=0010 for 2 cycles, then 0100 for 2 cycles, then 1000 for 2 cycles.
  - Then 0000 with done=1 for exactly 1 cycle; busy high for 6 cycles.
  - in_valid during the scan is ignored.
- Scan wrap, start=2:
  - Shows 0100, 1000, 0001, 0010 for 2 cycles each, then done pulse.
  - Repeat with start=3, wrap=0 -> 1000 for 2 cycles, then done.
- en/clear:
  - Scan with en=0 for 3 cycles mid-dwell -> output, counters and remaining dwell frozen; resumes exactly.
  - clear mid-scan -> 0000, busy=0, no done pulse; next accept is taken the following cycle.
- Wide config IN_W=3, DWELL=1, scan start=0, wrap=0 -> 8 consecutive one-hot values 0x01..0x80, one cycle each, then done. Assert one-hot-or-zero on every cycle throughout.
